// File: rtl/pzbcm_sram_pkg.sv
// Shared types and sizing helpers for the banked SRAM wrappers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pzbcm_sram_pkg;

  typedef enum logic {
    PZBCM_SRAM_INIT,
    PZBCM_SRAM_READY
  } pzbcm_sram_init_state;

  // Number of low pointer bits that select the bank; zero for a single bank.
  function automatic int get_bank_index_width(int banks);
    return (banks > 1) ? $clog2(banks) : 0;
  endfunction

  // Row address width inside one bank; never narrower than one bit.
  function automatic int get_bank_row_width(int words, int banks);
    int rows;
    rows = words / banks;
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/pzbcm_ram.sv
// Plain storage array: one synchronous write port, one asynchronous read port.
// Latency: write visible to the read port after the write edge; read is combinational.
// Backpressure: none; every enabled write is accepted.
module pzbcm_ram #(
  parameter int WORDS      = 128,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 7
) (
  input  logic                  i_clk,
  input  logic                  i_write_enable,
  input  logic [AW-1:0]         i_write_address,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [AW-1:0]         i_read_address,
  output logic [DATA_WIDTH-1:0] o_read_data
);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Storage write; the array itself is never reset (contents come from the init sweep).
  always_ff @(posedge i_clk) begin
    if (i_write_enable) begin
      mem[i_write_address] <= i_write_data;
    end
  end

  assign o_read_data = mem[i_read_address];

endmodule

// File: rtl/pzbcm_sram_1r1w_bank.sv
// One SRAM bank: write port plus a registered read port on top of pzbcm_ram.
// Latency: read data appears one cycle after i_read_enable; held otherwise.
// Backpressure: none; the bank accepts a read and a write every cycle.
module pzbcm_sram_1r1w_bank #(
  parameter int ROWS       = 128,
  parameter int DATA_WIDTH = 32,
  parameter int RW         = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_write_enable,
  input  logic [RW-1:0]         i_write_row,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic                  i_read_enable,
  input  logic [RW-1:0]         i_read_row,
  output logic [DATA_WIDTH-1:0] o_read_data
);

  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] rdata_q;

  pzbcm_ram #(
    .WORDS      (ROWS),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (RW)
  ) u_ram (
    .i_clk           (i_clk),
    .i_write_enable  (i_write_enable),
    .i_write_address (i_write_row),
    .i_write_data    (i_write_data),
    .i_read_address  (i_read_row),
    .o_read_data     (ram_rdata)
  );

  // Read register: captures only on this bank's read so the output holds between reads.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
    end else if (i_read_enable) begin
      rdata_q <= ram_rdata;
    end
  end

  assign o_read_data = rdata_q;

endmodule

// File: rtl/pzbcm_sram_1r1w_banked.sv
// Banked 1R1W SRAM with post-reset init sweep, read-valid tracking, 1- or 2-cycle reads.
// Latency: o_read_valid/o_read_data READ_LATENCY cycles after i_read_enable; sweep lasts WORDS/BANKS cycles.
// Backpressure: none; requests presented while o_init_busy is high are dropped.
// Option: define PZBCM_SRAM_1R1W_BANKED_BYPASS_EN for write-first same-pointer forwarding.
module pzbcm_sram_1r1w_banked
  import pzbcm_sram_pkg::*;
#(
  parameter int                    WORDS        = 256,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    BANKS        = 2,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_write_enable,
  input  logic [$clog2(WORDS)-1:0] i_write_pointer,
  input  logic [DATA_WIDTH-1:0]    i_write_data,
  input  logic                     i_read_enable,
  input  logic [$clog2(WORDS)-1:0] i_read_pointer,
  output logic [DATA_WIDTH-1:0]    o_read_data,
  output logic                     o_read_valid,
  output logic                     o_init_busy
);

  localparam int PW   = $clog2(WORDS);
  localparam int BB   = get_bank_index_width(BANKS);
  localparam int BIW  = (BB > 0) ? BB : 1;
  localparam int ROWS = WORDS / BANKS;
  localparam int RW   = get_bank_row_width(WORDS, BANKS);

  // Parameter legality.
  if ((WORDS % BANKS) != 0) begin : g_err_words
    $error("WORDS must be a multiple of BANKS");
  end
  if ((BANKS < 1) || (BANKS > 16) || ((BANKS & (BANKS - 1)) != 0)) begin : g_err_banks
    $error("BANKS must be a power of two in 1..16");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_err_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  // ---------------- init sweep ----------------
  pzbcm_sram_init_state state_q, state_d;
  logic [RW-1:0]        cnt_q, cnt_d;

  // State and row counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= PZBCM_SRAM_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep one row of every bank per cycle; READY is terminal until the next reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == PZBCM_SRAM_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == RW'(ROWS - 1)) begin
        state_d = PZBCM_SRAM_READY;
      end
    end
  end

  assign o_init_busy = (state_q == PZBCM_SRAM_INIT);

  // ---------------- address decode ----------------
  logic [BIW-1:0] wbank, rbank;
  logic [RW-1:0]  wrow, rrow;
  logic           w_in_range, r_in_range;

  assign wrow = RW'(i_write_pointer >> BB);
  assign rrow = RW'(i_read_pointer >> BB);

  if (BB == 0) begin : g_one_bank
    assign wbank = '0;
    assign rbank = '0;
  end else begin : g_multi_bank
    assign wbank = i_write_pointer[BB-1:0];
    assign rbank = i_read_pointer[BB-1:0];
  end

  if (WORDS == (2 ** PW)) begin : g_full_range
    assign w_in_range = 1'b1;
    assign r_in_range = 1'b1;
  end else begin : g_part_range
    assign w_in_range = ({1'b0, i_write_pointer} < (PW + 1)'(WORDS));
    assign r_in_range = ({1'b0, i_read_pointer} < (PW + 1)'(WORDS));
    always_ff @(posedge i_clk) begin
      if (i_rst_n && !o_init_busy) begin
        assert (!(i_write_enable && !w_in_range)) else $error("write pointer beyond WORDS");
        assert (!(i_read_enable && !r_in_range)) else $error("read pointer beyond WORDS");
      end
    end
  end

  logic write_ok, read_req, read_ok, byp_hit;
  assign write_ok = i_write_enable & ~o_init_busy & w_in_range;
  assign read_req = i_read_enable & ~o_init_busy;
  assign read_ok  = read_req & r_in_range;

  // ---------------- banks ----------------
  logic [BANKS-1:0]      bank_we, bank_re;
  logic [RW-1:0]         bank_waddr;
  logic [DATA_WIDTH-1:0] bank_wdata;
  logic [DATA_WIDTH-1:0] bank_rdata [BANKS];

  // Bank enables: all banks during the sweep, otherwise only the addressed one.
  always_comb begin
    bank_we    = '0;
    bank_re    = '0;
    bank_waddr = wrow;
    bank_wdata = i_write_data;
    if (o_init_busy) begin
      bank_we    = '1;
      bank_waddr = cnt_q;
      bank_wdata = INIT_VALUE;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        bank_we[b] = write_ok && (wbank == BIW'(b));
        bank_re[b] = read_ok && (rbank == BIW'(b));
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    pzbcm_sram_1r1w_bank #(
      .ROWS       (ROWS),
      .DATA_WIDTH (DATA_WIDTH),
      .RW         (RW)
    ) u_bank (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_write_enable (bank_we[b]),
      .i_write_row    (bank_waddr),
      .i_write_data   (bank_wdata),
      .i_read_enable  (bank_re[b]),
      .i_read_row     (rrow),
      .o_read_data    (bank_rdata[b])
    );
  end

  // ---------------- read pipeline ----------------
`ifdef PZBCM_SRAM_1R1W_BANKED_BYPASS_EN
  assign byp_hit = read_req && write_ok && (i_read_pointer == i_write_pointer);
  logic [DATA_WIDTH-1:0] bypdat1_q;

  // Forwarded write data; captured with the read so it stays aligned with the mux select.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bypdat1_q <= '0;
    end else if (read_req) begin
      bypdat1_q <= i_write_data;
    end
  end
`else
  assign byp_hit = 1'b0;
`ifndef SYNTHESIS
  // Collisions read unspecified data in this build; flag them in simulation.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && read_req && write_ok && (i_read_pointer == i_write_pointer)) begin
      $warning("same-pointer read/write without bypass: read data undefined");
    end
  end
`endif
`endif

  logic           rvld1_q;
  logic [BIW-1:0] rbank1_q;
  logic           rinv1_q;
  logic           byp1_q;

  // First read stage: valid plus the mux steering that travels with each request.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rvld1_q  <= 1'b0;
      rbank1_q <= '0;
      rinv1_q  <= 1'b0;
      byp1_q   <= 1'b0;
    end else begin
      rvld1_q <= read_req;
      if (read_req) begin
        rbank1_q <= rbank;
        rinv1_q  <= ~r_in_range;
        byp1_q   <= byp_hit;
      end
    end
  end

  logic [DATA_WIDTH-1:0] rdata1;

  // Output mux: bank data, INIT_VALUE for out-of-range reads, or forwarded write data.
  always_comb begin
    rdata1 = bank_rdata[rbank1_q];
    if (rinv1_q) begin
      rdata1 = INIT_VALUE;
    end
`ifdef PZBCM_SRAM_1R1W_BANKED_BYPASS_EN
    if (byp1_q) begin
      rdata1 = bypdat1_q;
    end
`endif
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign o_read_valid = rvld1_q;
    assign o_read_data  = rdata1;
  end else begin : g_lat2
    logic                  rvld2_q;
    logic [DATA_WIDTH-1:0] rdata2_q;

    // Extra output register; data holds between valid pulses.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        rvld2_q  <= 1'b0;
        rdata2_q <= '0;
      end else begin
        rvld2_q <= rvld1_q;
        if (rvld1_q) begin
          rdata2_q <= rdata1;
        end
      end
    end

    assign o_read_valid = rvld2_q;
    assign o_read_data  = rdata2_q;
  end

endmodule
